// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the VGA adapter plot port.
// Four requesters (background, ship, enemy, bullets) each ask for a solid
// rectangle fill. One winner at a time is latched and rasterised at one pixel
// per clock onto the 160x120 screen. Pixels that fall off the screen are
// clipped, but they still take their clock cycle.
module vga_draw_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] rect_x,
  input  logic [27:0] rect_y,
  input  logic [31:0] rect_w,
  input  logic [27:0] rect_h,
  input  logic [11:0] rect_colour,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        plot
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [8:0] SCREEN_W = 9'd160;
  localparam logic [8:0] SCREEN_H = 9'd120;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [7:0]  w_q, w_d;
  logic [6:0]  h_q, h_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [2:0]  vga_col_q, vga_col_d;
  logic        plot_q, plot_d;

  logic        rr_found;
  logic [1:0]  rr_winner;
  logic [1:0]  rr_cand;

  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [7:0]  sel_w;
  logic [6:0]  sel_h;
  logic [2:0]  sel_col;

  logic        last_col;
  logic        last_row;
  logic [7:0]  nx;
  logic [6:0]  ny;
  logic [8:0]  sum_x;
  logic [8:0]  sum_y;

  // Round-robin search starting just after the most recently served requester.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_q;
    rr_cand   = last_q;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_q + 2'(k);
      if (!rr_found && req[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  // Pick the winner's rectangle fields out of the packed request buses.
  always_comb begin
    sel_x   = rect_x[7:0];
    sel_y   = rect_y[6:0];
    sel_w   = rect_w[7:0];
    sel_h   = rect_h[6:0];
    sel_col = rect_colour[2:0];
    case (winner_q)
      2'd1: begin
        sel_x   = rect_x[15:8];
        sel_y   = rect_y[13:7];
        sel_w   = rect_w[15:8];
        sel_h   = rect_h[13:7];
        sel_col = rect_colour[5:3];
      end
      2'd2: begin
        sel_x   = rect_x[23:16];
        sel_y   = rect_y[20:14];
        sel_w   = rect_w[23:16];
        sel_h   = rect_h[20:14];
        sel_col = rect_colour[8:6];
      end
      2'd3: begin
        sel_x   = rect_x[31:24];
        sel_y   = rect_y[27:21];
        sel_w   = rect_w[31:24];
        sel_h   = rect_h[27:21];
        sel_col = rect_colour[11:9];
      end
      default: begin
        sel_x   = rect_x[7:0];
        sel_y   = rect_y[6:0];
        sel_w   = rect_w[7:0];
        sel_h   = rect_h[6:0];
        sel_col = rect_colour[2:0];
      end
    endcase
  end

  // Raster stepping: next column/row and the 9-bit screen position it lands on.
  always_comb begin
    last_col = (cx_q == (w_q - 8'd1));
    last_row = (cy_q == (h_q - 7'd1));
    if (last_col) begin
      nx = 8'd0;
      ny = cy_q + 7'd1;
    end else begin
      nx = cx_q + 8'd1;
      ny = cy_q;
    end
    sum_x = {1'b0, x_q} + {1'b0, nx};
    sum_y = {2'b00, y_q} + {2'b00, ny};
  end

  // Next-state and registered-output logic; the output registers always carry
  // the pixel being presented in the following cycle.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    winner_d  = winner_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    grant_d   = grant_q;
    done_d    = 4'd0;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d  = S_LATCH;
          winner_d = rr_winner;
          grant_d  = 4'b0001 << rr_winner;
        end
      end

      S_LATCH: begin
        x_d   = sel_x;
        y_d   = sel_y;
        w_d   = sel_w;
        h_d   = sel_h;
        col_d = sel_col;
        cx_d  = 8'd0;
        cy_d  = 7'd0;
        if (sel_w == 8'd0 || sel_h == 7'd0) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else begin
          state_d   = S_DRAW;
          vga_x_d   = sel_x;
          vga_y_d   = sel_y;
          vga_col_d = sel_col;
          plot_d    = ({1'b0, sel_x} < SCREEN_W) && ({2'b00, sel_y} < SCREEN_H);
        end
      end

      S_DRAW: begin
        if (last_col && last_row) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else begin
          cx_d      = nx;
          cy_d      = ny;
          vga_x_d   = sum_x[7:0];
          vga_y_d   = sum_y[6:0];
          vga_col_d = col_q;
          plot_d    = (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        last_d  = winner_q;
        grant_d = 4'd0;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = 4'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset; an aborted
  // draw simply vanishes, no completion pulse is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 2'd3;
      winner_q  <= 2'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      w_q       <= 8'd0;
      h_q       <= 7'd0;
      col_q     <= 3'd0;
      cx_q      <= 8'd0;
      cy_q      <= 7'd0;
      grant_q   <= 4'd0;
      done_q    <= 4'd0;
      busy_q    <= 1'b0;
      vga_x_q   <= 8'd0;
      vga_y_q   <= 7'd0;
      vga_col_q <= 3'd0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      winner_q  <= winner_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_col_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: scoreboard bench for the draw arbiter. Every rectangle
// handed to the DUT has its expected plotted pixels and completion pulse
// queued up front; a negedge monitor pops and compares them as they appear.
module tb_vga_draw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] rect_x;
  logic [27:0] rect_y;
  logic [31:0] rect_w;
  logic [27:0] rect_h;
  logic [11:0] rect_colour;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        plot;

  typedef logic [21:0] pix_t;

  pix_t        exp_pix[$];
  logic [3:0]  exp_done[$];
  pix_t        mon_pix;
  logic [3:0]  mon_done;

  int cyc        = 0;
  int plot_count = 0;
  int total      = 0;
  int bad        = 0;
  int t0;
  int pf;
  int got_cyc;

  vga_draw_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .rect_x     (rect_x),
    .rect_y     (rect_y),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .rect_colour(rect_colour),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .plot       (plot)
  );

  // 50 MHz clock.
  always #10 clk = ~clk;

  // Cycle counter; at negedge+1 it equals the index of the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Program requester idx's rectangle and queue what the screen should see.
  task automatic applyStimulus(input int idx, input int x, input int y, input int w,
                               input int h, input logic [2:0] col);
    logic [3:0] g;
    int px;
    int py;
    rect_x[idx*8 +: 8]      = 8'(x);
    rect_y[idx*7 +: 7]      = 7'(y);
    rect_w[idx*8 +: 8]      = 8'(w);
    rect_h[idx*7 +: 7]      = 7'(h);
    rect_colour[idx*3 +: 3] = col;
    g = 4'b0001 << idx;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = x + c;
        py = y + r;
        if (px < 160 && py < 120)
          exp_pix.push_back({g, 8'(px), 7'(py), col});
      end
    end
    exp_done.push_back(g);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for the next done pulse; -1 reports a timeout.
  task automatic waitDone(input string tag, input int want_cyc);
    got_cyc = -1;
    for (int n = 0; n < 400; n++) begin
      step();
      if (done !== 4'd0) begin
        got_cyc = cyc;
        break;
      end
    end
    checkOutput(tag, got_cyc, want_cyc);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_grant"}, grant, 4'd0);
    checkOutput({tag, "_done"}, done, 4'd0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_plot"}, plot, 1'b0);
    checkOutput({tag, "_vga_x"}, vga_x, 8'd0);
    checkOutput({tag, "_vga_y"}, vga_y, 7'd0);
    checkOutput({tag, "_vga_colour"}, vga_colour, 3'd0);
  endtask

  // Scoreboard monitor: every plotted pixel and every done pulse must match
  // the head of its expectation queue.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      plot_count++;
      if (exp_pix.size() == 0) begin
        checkOutput("plot_unexpected", plot, 1'b0);
      end else begin
        mon_pix = exp_pix.pop_front();
        checkOutput("pixel", {grant, vga_x, vga_y, vga_colour}, mon_pix);
      end
    end
    if (done !== 4'd0) begin
      if (exp_done.size() == 0) begin
        checkOutput("done_unexpected", done, 4'd0);
      end else begin
        mon_done = exp_done.pop_front();
        checkOutput("done_vec", done, mon_done);
        checkOutput("grant_at_done", grant, mon_done);
      end
    end
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios.
  initial begin
    reset       = 1'b1;
    req         = 4'd0;
    rect_x      = '0;
    rect_y      = '0;
    rect_w      = '0;
    rect_h      = '0;
    rect_colour = '0;
    repeat (3) step();
    checkAllZero("reset");
    reset = 1'b0;
    step();

    // Ship rectangle 3x2 at (10,20).
    applyStimulus(1, 10, 20, 3, 2, 3'b100);
    req = 4'b0010;
    t0  = cyc;
    pf  = plot_count;
    step();
    checkOutput("t1_grant", grant, 4'b0010);
    checkOutput("t1_busy", busy, 1'b1);
    checkOutput("t1_plot_latch", plot, 1'b0);
    step();
    checkOutput("t1_first_plot", plot, 1'b1);
    waitDone("t1_done_cyc", t0 + 8);
    req = 4'd0;
    step();
    checkOutput("t1_busy_low", busy, 1'b0);
    checkOutput("t1_grant_low", grant, 4'd0);
    checkOutput("t1_plots", plot_count - pf, 6);

    // All four requesting 1x1 rects: order 0,1,2,3,0 from reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++)
      applyStimulus(i, 5 + i * 20, 3 + i * 10, 1, 1, 3'(i + 1));
    applyStimulus(0, 5, 3, 1, 1, 3'd1);
    req = 4'b1111;
    t0  = cyc;
    pf  = plot_count;
    for (int k = 0; k < 5; k++)
      waitDone("t2_done_cyc", t0 + 3 + 4 * k);
    req = 4'd0;
    step();
    checkOutput("t2_busy_low", busy, 1'b0);
    checkOutput("t2_plots", plot_count - pf, 5);

    // Zero-width rectangle on bullets: nothing plotted.
    applyStimulus(3, 40, 50, 0, 5, 3'b111);
    req = 4'b1000;
    t0  = cyc;
    pf  = plot_count;
    step();
    checkOutput("t4_grant", grant, 4'b1000);
    waitDone("t4_done_cyc", t0 + 2);
    req = 4'd0;
    step();
    checkOutput("t4_busy_low", busy, 1'b0);
    checkOutput("t4_plots", plot_count - pf, 0);

    // Clipping at the bottom-right corner.
    applyStimulus(0, 158, 118, 4, 3, 3'b010);
    req = 4'b0001;
    t0  = cyc;
    pf  = plot_count;
    waitDone("t3_done_cyc", t0 + 14);
    req = 4'd0;
    step();
    checkOutput("t3_plots", plot_count - pf, 4);

    // Reset during a 10x10 draw after 37 pixels.
    applyStimulus(2, 5, 5, 10, 10, 3'b101);
    req = 4'b0100;
    pf  = plot_count;
    for (int n = 0; n < 200; n++) begin
      step();
      if (plot_count - pf == 37) break;
    end
    checkOutput("t5_pixels_before_reset", plot_count - pf, 37);
    reset = 1'b1;
    req   = 4'd0;
    exp_pix.delete();
    exp_done.delete();
    step();
    checkAllZero("t5_reset");
    reset = 1'b0;
    repeat (4) step();
    checkOutput("t5_idle_busy", busy, 1'b0);
    applyStimulus(0, 70, 60, 1, 1, 3'b001);
    applyStimulus(1, 71, 60, 1, 1, 3'b110);
    req = 4'b0011;
    t0  = cyc;
    step();
    checkOutput("t5_grant_first", grant, 4'b0001);
    waitDone("t5_done0_cyc", t0 + 3);
    req = 4'b0010;
    waitDone("t5_done1_cyc", t0 + 7);
    req = 4'd0;
    step();
    checkOutput("t5_busy_low", busy, 1'b0);

    // Request dropped and inputs changed mid-draw: latched values persist.
    applyStimulus(2, 30, 40, 5, 2, 3'b011);
    req = 4'b0100;
    t0  = cyc;
    pf  = plot_count;
    repeat (4) step();
    req                = 4'd0;
    rect_x[23:16]      = 8'd100;
    rect_w[23:16]      = 8'd1;
    rect_colour[8:6]   = 3'b000;
    waitDone("t6_done_cyc", t0 + 12);
    step();
    checkOutput("t6_busy_low", busy, 1'b0);
    repeat (3) step();
    checkOutput("t6_no_regrant", grant, 4'd0);
    checkOutput("t6_plots", plot_count - pf, 10);

    checkOutput("final_pix_queue", exp_pix.size(), 0);
    checkOutput("final_done_queue", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
